// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller for the EXE stage.
//
// Accepts one operation per start pulse (while idle or holding a result),
// runs it on a two-stage multiplier or a radix-2 restoring divider, then
// holds the selected 32-bit result with result_valid until the next
// accepted start or a flush.
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           asynchronous, active-high reset
//   start         issue pulse; op/src_a/src_b sampled on the same edge
//   op[2:0]       000 MUL.W, 001 MULH.W, 010 MULH.WU, 011 reserved (MUL.W),
//                 100 DIV.W, 101 MOD.W, 110 DIV.WU, 111 MOD.WU
//   src_a[31:0]   dividend / multiplicand
//   src_b[31:0]   divisor / multiplier
//   flush         cancel from the commit side; beats start in the same cycle
//   busy          registered, high exactly while in MUL or DIV
//   result_valid  registered, high while a completed unflushed result is held
//   result[31:0]  product half, quotient or remainder
//
// Handshake: start is a single-cycle request with no ready return; it is
// taken only when busy is low and flush is low, otherwise dropped.
//
// Build option: define MDU_DIVZERO_FAST_EN to finish a divide by zero in
// one busy cycle instead of running the full 32 iterations. Result values
// are identical in both builds.

module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Latched operation
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    // Multiplier stage register
    logic [63:0] prod_q;

    // Divider working registers
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        q_neg;
    logic        r_neg;
    logic        dz_q;

    // cnt: in MUL it selects the pipeline stage (0,1); in DIV 0 is the
    // setup cycle and 1..32 are the iterations.
    logic [5:0]  cnt;

    // Combinational datapath
    logic        signed_div;
    logic        mul_signed;
    logic        mul_high;
    logic [63:0] mul_a64;
    logic [63:0] mul_b64;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] rem_sh;
    logic [32:0] sub;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] dz_res;
    logic [31:0] div_res;
    logic [31:0] mul_res;

    always_comb begin
        signed_div = ~op_q[1];
        mul_signed = (op_q == 3'b001);
        mul_high   = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);

        // 33-bit operands (sign- or zero-extended) widened to 64 bits;
        // the low 64 bits of the product are all that is ever selected.
        mul_a64 = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b64 = {{32{mul_signed & b_q[31]}}, b_q};
        mul_res = mul_high ? prod_q[63:32] : prod_q[31:0];

        mag_a = (signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
        mag_b = (signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;

        // One restoring step. The partial remainder is below the divisor,
        // so rem_sh - dvs lies strictly inside +/-2^32 and bit 32 of the
        // 33-bit difference is its sign.
        rem_sh = {rem_q, quo_q[31]};
        sub    = rem_sh - {1'b0, dvs_q};
        if (sub[32]) begin
            rem_nxt = rem_sh[31:0];
            quo_nxt = {quo_q[30:0], 1'b0};
        end else begin
            rem_nxt = sub[31:0];
            quo_nxt = {quo_q[30:0], 1'b1};
        end

        // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negated
        // is 0x80000000, remainder 0.
        q_fin = q_neg ? (~quo_nxt + 32'd1) : quo_nxt;
        r_fin = r_neg ? (~rem_nxt + 32'd1) : rem_nxt;

        dz_res = op_q[0] ? a_q : 32'hFFFF_FFFF;
        if (dz_q) begin
            div_res = dz_res;
        end else begin
            div_res = op_q[0] ? r_fin : q_fin;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = op[2] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (cnt == 6'd1) begin
                        state_nxt = DONE;
                    end
                end
                DIV: begin
                    if (cnt == 6'd32) begin
                        state_nxt = DONE;
                    end
`ifdef MDU_DIVZERO_FAST_EN
                    if ((cnt == 6'd0) && (b_q == 32'd0)) begin
                        state_nxt = DONE;
                    end
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt == MUL) || (state_nxt == DIV);
            result_valid <= (state_nxt == DONE);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 3'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            prod_q <= 64'd0;
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            dvs_q  <= 32'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz_q   <= 1'b0;
            cnt    <= 6'd0;
            result <= 32'd0;
        end else if (flush) begin
            cnt <= 6'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= src_a;
                        b_q   <= src_b;
                        cnt   <= 6'd0;
                    end
                end
                MUL: begin
                    if (cnt == 6'd0) begin
                        prod_q <= mul_a64 * mul_b64;
                        cnt    <= 6'd1;
                    end else begin
                        result <= mul_res;
                        cnt    <= 6'd0;
                    end
                end
                DIV: begin
                    if (cnt == 6'd0) begin
                        // Setup: magnitudes and result signs
                        rem_q <= 32'd0;
                        quo_q <= mag_a;
                        dvs_q <= mag_b;
                        q_neg <= signed_div && (a_q[31] ^ b_q[31]);
                        r_neg <= signed_div && a_q[31];
                        dz_q  <= (b_q == 32'd0);
`ifdef MDU_DIVZERO_FAST_EN
                        if (b_q == 32'd0) begin
                            result <= dz_res;
                        end else begin
                            cnt <= 6'd1;
                        end
`else
                        cnt <= 6'd1;
`endif
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        if (cnt == 6'd32) begin
                            result <= div_res;
                            cnt    <= 6'd0;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                default: cnt <= 6'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- directed plus random bench for mdu_ctrl.
//
// Inputs are driven on the falling edge, outputs sampled on the falling
// edge. Expected results are pushed to exp_q when an operation is issued
// and popped when result_valid rises; latency and busy cycles are checked
// against the operation class.

module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

    mdu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        sa = a;
        sb = b;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'd0, a} * {32'd0, b};
        model = 32'd0;
        case (o)
            3'd0, 3'd3: model = up[31:0];
            3'd1:       model = sp[63:32];
            3'd2:       model = up[63:32];
            3'd4: begin
                if (b == 32'd0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
                else model = sa / sb;
            end
            3'd5: begin
                if (b == 32'd0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'd0;
                else model = sa % sb;
            end
            3'd6: model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd7: model = (b == 32'd0) ? a : a % b;
            default: model = 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] b);
        if (!o[2]) return 2;
`ifdef MDU_DIVZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Drive one start pulse; returns at the falling edge of cycle T+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for result_valid, counting cycles from T+1. poke_at > 0 drives a
    // junk start on that busy cycle, which must be ignored.
    task automatic wait_check(input string tag, input int exp_lat, input int poke_at);
        int          n;
        int          busy_cnt;
        logic [31:0] exp;
        n = 1;
        busy_cnt = 0;
        while (result_valid !== 1'b1 && n <= 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (n == poke_at) begin
                op    = 3'($urandom_range(0, 7));
                src_a = $urandom;
                src_b = $urandom;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        check({tag, " valid"}, {31'd0, result_valid}, 32'd1);
        check({tag, " latency"}, 32'(n - 1), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, " result"}, result, exp);
        last_exp = exp;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int poke_at);
        exp_q.push_back(exp);
        issue(o, a, b);
        wait_check(tag, latency(o, b), poke_at);
    endtask

    initial begin
        logic        saw;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);

        // Release and issue on the very first rising edge afterwards
        rst = 1'b0;
        run_op("first_mulw", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);

        // Multiply vectors
        run_op("mulhwu_a", 3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0);
        run_op("mulhw", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
        run_op("mulhwu_b", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0);
        run_op("mul_rsvd", 3'd3, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 0);

        // Divide vectors
        run_op("divw_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("modw_neg", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("divwu", 3'd6, 32'd100, 32'd7, 32'd14, 0);
        run_op("modwu", 3'd7, 32'd100, 32'd7, 32'd2, 0);
        run_op("divw_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("modw_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("divwu_z", 3'd6, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("modwu_z", 3'd7, 32'd5, 32'd0, 32'd5, 0);
        run_op("divw_z", 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("modw_z", 3'd5, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);

        // DONE holds its result
        repeat (3) @(negedge clk);
        check("hold valid", {31'd0, result_valid}, 32'd1);
        check("hold result", result, last_exp);

        // Flush in DONE drops the result
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done valid", {31'd0, result_valid}, 32'd0);
        check("flush_done busy", {31'd0, busy}, 32'd0);

        // start together with flush in IDLE: nothing starts
        op = 3'd0; src_a = 32'd3; src_b = 32'd5;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("start_flush valid", {31'd0, result_valid}, 32'd0);

        // start while busy is ignored
        run_op("ign_div", 3'd6, 32'd100, 32'd7, 32'd14, 5);
        run_op("ign_mul", 3'd0, 32'd3, 32'd5, 32'd15, 1);

        // Flush on the 10th busy cycle of a divide, restart one cycle later
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div busy", {31'd0, busy}, 32'd0);
        check("flush_div valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        run_op("after_flush", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);

        // Random operations
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            run_op("rand", o, a, b, model(o, a, b), 0);
        end

        // Reset mid-divide: immediate clear, no result afterwards
        issue(3'd6, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        check("rst_mid valid", {31'd0, result_valid}, 32'd0);
        check("rst_mid result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        check("rst_mid no_result", {31'd0, saw}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  EXE-stage issue pulse; operands and op sampled at the same edge.
REQ-004 op  input  3  000 MUL.W, 001 MULH.W, 010 MULH.WU, 011 reserved (executes as MUL.W), 100 DIV.W, 101 MOD.W, 110 DIV.WU, 111 MOD.WU.
REQ-005 src_a  input  32  dividend / multiplicand.
REQ-006 src_b  input  32  divisor / multiplier.
REQ-007 flush  input  1  exception/branch cancel from the commit side.
REQ-008 busy  output  1  registered; drives the MDU_busy input of the stall unit.
REQ-009 result_valid  output  1  registered; result holds a completed, unflushed operation.
REQ-010 result  output  32  selected product half, quotient or remainder.

Function
REQ-011 FSM states: IDLE, MUL, DIV, DONE; busy SHALL equal (state==MUL or state==DIV).
REQ-012 IDLE or DONE plus start (flush low): latch op/operands; go to MUL for multiply ops, DIV for divide ops; clear result_valid.
REQ-013 start while busy SHALL be ignored; operands, counter and result unaffected.
REQ-014 Latency L: issue edge at cycle T; busy=1 in cycles T+1..T+L; busy=0 and result_valid=1 from T+L+1.
REQ-015 Multiply: two-stage registered 33x33 signed product (operands sign- or zero-extended per op); L=2; MUL.W returns bits[31:0], MULH.W/MULH.WU return bits[63:32].
REQ-016 Divide: radix-2 restoring on magnitudes; 1 setup cycle (abs values, sign capture) plus 32 iterations via 6-bit counter; L=33.
REQ-017 Signed divide: quotient truncated toward zero; remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give q=0x80000000, r=0.
REQ-018 Divide by zero (non-fast path): q=0xFFFFFFFF, r=src_a, for signed and unsigned ops alike.
REQ-019 DONE: result and result_valid held until the next accepted start or a flush.
REQ-020 flush in any state: next state IDLE, result_valid=0, busy=0 on the next cycle; in-flight result discarded.
REQ-021 flush and start in the same cycle: flush wins; start discarded.
REQ-022 Counter is only meaningful in DIV; it SHALL not wrap into a second division pass; the 32nd iteration SHALL transition to DONE.

Reset
REQ-023 rst SHALL immediately force state=IDLE, busy=0, result_valid=0, result=0, counter=0.
REQ-024 rst asserted mid-operation SHALL abandon the operation; no result is produced after release.
REQ-025 First start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro MDU_DIVZERO_FAST_EN defined: divide op with src_b==0 SHALL skip DIV and finish with L=1, producing the values of REQ-018.
REQ-027 Macro MDU_DIVZERO_FAST_EN undefined: divide-by-zero SHALL take the full L=33 and produce identical values.

Verification
REQ-028 MUL.W 0x00010000 x 0x00010000 -> busy 2 cycles, result=0x00000000; MULH.WU same operands -> 0x00000001.
REQ-029 MULH.W 0xFFFFFFFF x 0x00000002 -> result=0xFFFFFFFF; MULH.WU same -> 0x00000001.
REQ-030 DIV.W 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD after exactly 33 busy cycles; MOD.W -> 0xFFFFFFFF; DIV.WU 100/7 -> 14, MOD.WU -> 2.
REQ-031 DIV.W 0x80000000 / 0xFFFFFFFF -> 0x80000000; DIVU 5 / 0 -> 0xFFFFFFFF, MODU -> 5; busy 1 cycle with MDU_DIVZERO_FAST_EN, 33 without.
REQ-032 flush at cycle 10 of a DIV -> busy=0 and result_valid=0 next cycle; a new start 1 cycle later completes correctly.
REQ-033 start asserted during busy with different operands -> ignored, original result delivered; start+flush together in IDLE -> no operation started.
